inst_encoder: RTL and testbench

Encodes a stream of abstract RV32I instruction commands into 32-bit machine words and writes them sequentially into instruction memory. It is the inverse of the control/decode path and is used as the on-chip program loader for the single-cycle/pipelined CPU labs. It expands the LI pseudo-instruction into LUI+ADDI, tracks the write address, and flags unencodable commands.

---
 rtl/rv_pkg.sv | 46 ++++
 rtl/inst_pack.sv | 79 +++++++
 rtl/inst_encoder.sv | 130 +++++++++++++
 tb/tb_inst_encoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the program loader and the control path.
// Holds the major opcodes, the loader command classes and immediate-range helpers.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;

  // Major opcodes, identical to the values decoded by control.
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  // Loader command classes carried on in_op; 11..15 are illegal.
  typedef enum logic [3:0] {
    OP_R     = 4'd0,
    OP_IALU  = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_BR    = 4'd4,
    OP_LUI   = 4'd5,
    OP_AUIPC = 4'd6,
    OP_JAL   = 4'd7,
    OP_JALR  = 4'd8,
    OP_LI    = 4'd9,
    OP_CLR   = 4'd10
  } op_e;

  // True when v is representable as a signed value of 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  // Branch/jump offsets: signed range and halfword aligned.
  function automatic logic fits_even(input logic [XLEN-1:0] v, input int unsigned bits);
    return fits_signed(v, bits) && !v[0];
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer.
// Ports: op_i/rd_i/rs1_i/rs2_i/f3_i/alt_i/imm_i command fields in;
//        word0_o first machine word, word1_o second word of a two-word LI,
//        two_o LI needs the second word, ok_o command is legal and in range.
module inst_pack
  import rv_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [4:0]      rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [2:0]      f3_i,
  input  logic            alt_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] word0_o,
  output logic [XLEN-1:0] word1_o,
  output logic            two_o,
  output logic            ok_o
);

  logic [6:0]      f7;
  logic [XLEN-1:0] li_upper;

  // Field placement per RV32I format; LI picks ADDI or LUI(+ADDI).
  always_comb begin
    word0_o  = '0;
    word1_o  = '0;
    two_o    = 1'b0;
    ok_o     = 1'b1;
    f7       = {1'b0, alt_i, 5'b00000};
    // Rounding by 0x800 compensates for the sign-extended low ADDI.
    li_upper = imm_i + 32'h0000_0800;
    case (op_i)
      OP_R: word0_o = {f7, rs2_i, rs1_i, f3_i, rd_i, OPC_OP};
      OP_IALU: begin
        ok_o = fits_signed(imm_i, 12);
        if (f3_i == 3'b001 || f3_i == 3'b101)
          word0_o = {f7, imm_i[4:0], rs1_i, f3_i, rd_i, OPC_OP_IMM};
        else
          word0_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OPC_OP_IMM};
      end
      OP_LOAD: begin
        ok_o    = fits_signed(imm_i, 12);
        word0_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OPC_LOAD};
      end
      OP_STORE: begin
        ok_o    = fits_signed(imm_i, 12);
        word0_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], OPC_STORE};
      end
      OP_BR: begin
        ok_o    = fits_even(imm_i, 13);
        word0_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                   imm_i[4:1], imm_i[11], OPC_BRANCH};
      end
      OP_LUI:   word0_o = {imm_i[19:0], rd_i, OPC_LUI};
      OP_AUIPC: word0_o = {imm_i[19:0], rd_i, OPC_AUIPC};
      OP_JAL: begin
        ok_o    = fits_even(imm_i, 21);
        word0_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      end
      OP_JALR: begin
        ok_o    = fits_signed(imm_i, 12);
        word0_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      end
      OP_LI: begin
        if (fits_signed(imm_i, 12)) begin
          word0_o = {imm_i[11:0], 5'd0, 3'b000, rd_i, OPC_OP_IMM};
        end else begin
          word0_o = {li_upper[31:12], rd_i, OPC_LUI};
          two_o   = (imm_i[11:0] != 12'd0);
          word1_o = {imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OP_IMM};
        end
      end
      OP_CLR:  ok_o = 1'b1;
      default: ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: encodes RV32I commands and writes them into instruction memory.
// Ports: clk/rstn clock and async active-low reset; in_valid/in_ready command
//        handshake with fields in_op..in_imm; im_we/im_addr/im_wdata memory write;
//        count words written, full memory full, err command dropped.
// DEPTH must not exceed 2**ADDR_W.
module inst_encoder
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic              in_alt,
  input  logic [XLEN-1:0]   in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [XLEN-1:0]   im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned          CntW   = ADDR_W + 1;
  localparam logic [CntW-1:0]      DepthC = CntW'(DEPTH);

  typedef enum logic {S_IDLE, S_EXPAND} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic              full_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   pend_q;

  logic [XLEN-1:0]   word0;
  logic [XLEN-1:0]   word1;
  logic              two;
  logic              ok;
  logic              is_clr;
  logic              accept;
  logic              last_slot;

  inst_pack u_pack (
    .op_i    (in_op),
    .rd_i    (in_rd),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .f3_i    (in_f3),
    .alt_i   (in_alt),
    .imm_i   (in_imm),
    .word0_o (word0),
    .word1_o (word1),
    .two_o   (two),
    .ok_o    (ok)
  );

  // CLR is the only command that gets through while full.
  assign is_clr    = (in_op == OP_CLR);
  assign in_ready  = (state_q == S_IDLE) && (!full_q || is_clr);
  assign accept    = in_valid && in_ready;
  assign count_d   = count_q + CntW'(1);
  assign last_slot = (count_d == DepthC);

  // Loader FSM, address counter and registered write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_clr) begin
              count_q <= '0;
              full_q  <= 1'b0;
            end else if (!ok || (two && last_slot)) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= count_q[ADDR_W-1:0];
              wdata_q <= word0;
              count_q <= count_d;
              full_q  <= last_slot;
              if (two) begin
                pend_q  <= word1;
                state_q <= S_EXPAND;
              end
            end
          end
        end
        S_EXPAND: begin
          we_q    <= 1'b1;
          addr_q  <= count_q[ADDR_W-1:0];
          wdata_q <= pend_q;
          count_q <= count_d;
          full_q  <= last_slot;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a default build (A) and a DEPTH=4 build (B)
// share command fields and reset; each has its own valid.
module tb_inst_encoder;

  logic        clk;
  logic        rstn;
  logic        vld_a, vld_b;
  logic        rdy_a, rdy_b;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_f3;
  logic        in_alt;
  logic [31:0] in_imm;

  logic        we_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;

  logic        we_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  inst_encoder #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(vld_a), .in_ready(rdy_a),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_f3(in_f3), .in_alt(in_alt), .in_imm(in_imm),
    .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a),
    .count(cnt_a), .full(full_a), .err(err_a)
  );

  inst_encoder #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(vld_b), .in_ready(rdy_b),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_f3(in_f3), .in_alt(in_alt), .in_imm(in_imm),
    .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b),
    .count(cnt_b), .full(full_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a command at negedge, wait for ready, let it be accepted, return 1ns after the edge.
  task automatic issue(input bit b, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic alt, input logic [31:0] imm);
    int n;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_f3 = f3; in_alt = alt; in_imm = imm;
    vld_a = !b; vld_b = b;
    n = 0;
    while (!(b ? rdy_b : rdy_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    vld_a = 1'b0; vld_b = 1'b0;
  endtask

  task automatic exp_wr(input bit b, input string tag, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] cnt);
    chk({tag, ".we"},    b ? 32'(we_b)    : 32'(we_a),    32'd1);
    chk({tag, ".addr"},  b ? 32'(addr_b)  : 32'(addr_a),  addr);
    chk({tag, ".wdata"}, b ? wdata_b      : wdata_a,      data);
    chk({tag, ".count"}, b ? 32'(cnt_b)   : 32'(cnt_a),   cnt);
  endtask

  task automatic exp_err(input bit b, input string tag, input logic [31:0] cnt);
    chk({tag, ".err"},   b ? 32'(err_b) : 32'(err_a), 32'd1);
    chk({tag, ".we"},    b ? 32'(we_b)  : 32'(we_a),  32'd0);
    chk({tag, ".count"}, b ? 32'(cnt_b) : 32'(cnt_a), cnt);
  endtask

  initial begin
    rstn = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_f3 = 3'd0; in_alt = 1'b0; in_imm = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we",    32'(we_a),   32'd0);
    chk("rst.addr",  32'(addr_a), 32'd0);
    chk("rst.wdata", wdata_a,     32'd0);
    chk("rst.count", 32'(cnt_a),  32'd0);
    chk("rst.full",  32'(full_a), 32'd0);
    chk("rst.err",   32'(err_a),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst.ready", 32'(rdy_a), 32'd1);

    // R-type ADD x3,x1,x2
    issue(0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    exp_wr(0, "add", 32'd0, 32'h002081B3, 32'd1);
    @(posedge clk); #1;
    chk("add.pulse", 32'(we_a), 32'd0);

    // CLR resets the address without a write
    issue(0, 4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    chk("clr.we",    32'(we_a),  32'd0);
    chk("clr.err",   32'(err_a), 32'd0);
    chk("clr.count", 32'(cnt_a), 32'd0);

    issue(0, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    exp_wr(0, "addi", 32'd0, 32'h00500093, 32'd1);
    issue(0, 4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
    exp_wr(0, "sw", 32'd1, 32'h0020A423, 32'd2);

    issue(0, 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    exp_wr(0, "beq", 32'd2, 32'hFE208EE3, 32'd3);
    issue(0, 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFD);
    exp_err(0, "beq_odd", 32'd3);
    @(posedge clk); #1;
    chk("beq_odd.pulse", 32'(err_a), 32'd0);

    // LI needing LUI+ADDI; ready low during the expansion cycle
    issue(0, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5678);
    exp_wr(0, "li_lui", 32'd3, 32'h123452B7, 32'd4);
    chk("li.ready_lo", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    exp_wr(0, "li_addi", 32'd4, 32'h67828293, 32'd5);
    chk("li.ready_hi", 32'(rdy_a), 32'd1);

    issue(0, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
    exp_wr(0, "li_lui_only", 32'd5, 32'h123452B7, 32'd6);
    @(posedge clk); #1;
    chk("li_lui_only.no2nd", 32'(we_a), 32'd0);

    issue(0, 4'd9, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFB);
    exp_wr(0, "li_small", 32'd6, 32'hFFB00393, 32'd7);

    issue(0, 4'd1, 5'd2, 5'd3, 5'd0, 3'b101, 1'b1, 32'd4);
    exp_wr(0, "srai", 32'd7, 32'h4041D113, 32'd8);

    issue(0, 4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    exp_wr(0, "jal", 32'd8, 32'h008000EF, 32'd9);

    issue(0, 4'd2, 5'd1, 5'd2, 5'd0, 3'b010, 1'b0, 32'd2048);
    exp_err(0, "lw_range", 32'd9);
    issue(0, 4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'hFFFF_F7FF);
    exp_err(0, "sw_range", 32'd9);
    issue(0, 4'd12, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    exp_err(0, "illegal", 32'd9);
    issue(0, 4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
    exp_err(0, "jal_odd", 32'd9);

    issue(0, 4'd8, 5'd0, 5'd1, 5'd0, 3'd3, 1'b0, 32'd0);
    exp_wr(0, "jalr", 32'd9, 32'h00008067, 32'd10);

    // Reset during expansion drops the second word
    issue(0, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5678);
    exp_wr(0, "li_rst", 32'd10, 32'h123452B7, 32'd11);
    rstn = 1'b0;
    #1;
    chk("mid_rst.we",    32'(we_a),   32'd0);
    chk("mid_rst.addr",  32'(addr_a), 32'd0);
    chk("mid_rst.wdata", wdata_a,     32'd0);
    chk("mid_rst.count", 32'(cnt_a),  32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.we", 32'(we_a), 32'd0);
    @(posedge clk); #1;
    chk("post_rst.we2",   32'(we_a),  32'd0);
    chk("post_rst.count", 32'(cnt_a), 32'd0);

    // DEPTH=4 build: fill, full, CLR, last-slot LI
    for (int i = 0; i < 4; i++) begin
      issue(1, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
      exp_wr(1, $sformatf("fill%0d", i), 32'(i), {12'(i), 20'h00093}, 32'(i + 1));
      chk($sformatf("fill%0d.full", i), 32'(full_b), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("full.ready", 32'(rdy_b), 32'd0);
    issue(1, 4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    chk("clr4.count", 32'(cnt_b),  32'd0);
    chk("clr4.full",  32'(full_b), 32'd0);
    chk("clr4.err",   32'(err_b),  32'd0);
    issue(1, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    exp_wr(1, "after_clr", 32'd0, 32'h002081B3, 32'd1);
    issue(1, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    exp_wr(1, "b_w1", 32'd1, 32'h00500093, 32'd2);
    issue(1, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    exp_wr(1, "b_w2", 32'd2, 32'h00500093, 32'd3);
    issue(1, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5678);
    exp_err(1, "li_last_slot", 32'd3);
    chk("li_last_slot.full", 32'(full_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
